// File: rtl/cursor_pkg.sv
// Shared types and default raster constants for the cursor overlay engine.
package cursor_pkg;

    typedef enum logic [1:0] {
        CUR_PLUS  = 2'd0,
        CUR_BOX   = 2'd1,
        CUR_CROSS = 2'd2,
        CUR_OFF   = 2'd3
    } cur_mode_e;

    localparam int H_RES_DEFAULT = 640;
    localparam int V_RES_DEFAULT = 480;

endpackage

// File: rtl/cursor_shape.sv
// Combinational hit test: decides whether a signed offset from the cursor
// centre falls on the selected cursor shape.
module cursor_shape
    import cursor_pkg::*;
#(
    parameter int DXW = 11,
    parameter int DYW = 10,
    parameter int ARM = 2
) (
    input  logic signed [DXW-1:0] dx,
    input  logic signed [DYW-1:0] dy,
    input  cur_mode_e             mode,
    output logic                  hit
);

    localparam logic [DXW-1:0] ARM_X = DXW'(ARM);
    localparam logic [DYW-1:0] ARM_Y = DYW'(ARM);

    logic [DXW-1:0] adx;
    logic [DYW-1:0] ady;
    logic           dx_zero;
    logic           dy_zero;

    // Offsets are one bit wider than the coordinates, so the negation never overflows.
    assign adx     = dx[DXW-1] ? $unsigned(-dx) : $unsigned(dx);
    assign ady     = dy[DYW-1] ? $unsigned(-dy) : $unsigned(dy);
    assign dx_zero = (dx == '0);
    assign dy_zero = (dy == '0);

    always_comb begin
        hit = 1'b0;
        case (mode)
            CUR_PLUS:  hit = (dy_zero && (adx <= ARM_X)) || (dx_zero && (ady <= ARM_Y));
            CUR_BOX:   hit = ((adx == ARM_X) && (ady <= ARM_Y)) ||
                             ((ady == ARM_Y) && (adx <= ARM_X));
            CUR_CROSS: hit = dx_zero || dy_zero;
            default:   hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/cursor_engine.sv
// Cursor overlay: frame-synchronous position update from move pulses,
// blink timing, and a one-cycle registered hit flag for the raster.
module cursor_engine
    import cursor_pkg::*;
#(
    parameter int H_RES        = H_RES_DEFAULT,
    parameter int V_RES        = V_RES_DEFAULT,
    parameter int ARM          = 2,
    parameter int STEP         = 1,
    parameter int BLINK_FRAMES = 30,
    localparam int XW          = $clog2(H_RES),
    localparam int YW          = $clog2(V_RES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_tick,
    input  logic          move_up,
    input  logic          move_down,
    input  logic          move_left,
    input  logic          move_right,
    input  logic [1:0]    mode,
    input  logic          blink_en,
    input  logic [XW-1:0] xPos,
    input  logic [YW-1:0] yPos,
    input  logic          pixelActive,
    output logic [XW-1:0] cursorX,
    output logic [YW-1:0] cursorY,
    output logic          isCursor
);

    localparam logic [XW:0]   STEP_X   = (XW+1)'(STEP);
    localparam logic [YW:0]   STEP_Y   = (YW+1)'(STEP);
    localparam logic [XW:0]   X_MAX    = (XW+1)'(H_RES - 1);
    localparam logic [YW:0]   Y_MAX    = (YW+1)'(V_RES - 1);
    localparam logic [XW-1:0] X_HOME   = XW'(H_RES / 2);
    localparam logic [YW-1:0] Y_HOME   = YW'(V_RES / 2);
    localparam logic [7:0]    BLINK_TC = 8'(BLINK_FRAMES - 1);

    // pend bit order: {up, down, left, right}
    logic [3:0]    pend_q, pend_d, pend_eff;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          vis_q, vis_d;
    logic          is_cursor_q;

    logic [XW:0]   x_inc, x_sub;
    logic [YW:0]   y_inc, y_sub;
    logic          moved;

    logic signed [XW:0] dx;
    logic signed [YW:0] dy;
    logic               hit;

    assign pend_eff = pend_q | {move_up, move_down, move_left, move_right};

    assign x_inc = {1'b0, x_q} + STEP_X;
    assign x_sub = {1'b0, x_q} - STEP_X;
    assign y_inc = {1'b0, y_q} + STEP_Y;
    assign y_sub = {1'b0, y_q} - STEP_Y;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pend_eff[0] && !pend_eff[1]) begin
            x_d = (x_inc > X_MAX) ? X_MAX[XW-1:0] : x_inc[XW-1:0];
        end else if (pend_eff[1] && !pend_eff[0]) begin
            x_d = x_sub[XW] ? '0 : x_sub[XW-1:0];
        end
        // Down increases the row index.
        if (pend_eff[2] && !pend_eff[3]) begin
            y_d = (y_inc > Y_MAX) ? Y_MAX[YW-1:0] : y_inc[YW-1:0];
        end else if (pend_eff[3] && !pend_eff[2]) begin
            y_d = y_sub[YW] ? '0 : y_sub[YW-1:0];
        end
    end

    assign moved  = (x_d != x_q) || (y_d != y_q);
    assign pend_d = frame_tick ? 4'b0000 : pend_eff;

    always_comb begin
        cnt_d = cnt_q;
        vis_d = vis_q;
        if (!blink_en || (frame_tick && moved)) begin
            cnt_d = 8'd0;
            vis_d = 1'b1;
        end else if (frame_tick) begin
            if (cnt_q == BLINK_TC) begin
                cnt_d = 8'd0;
                vis_d = ~vis_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    assign dx = $signed({1'b0, xPos}) - $signed({1'b0, x_q});
    assign dy = $signed({1'b0, yPos}) - $signed({1'b0, y_q});

    cursor_shape #(
        .DXW (XW + 1),
        .DYW (YW + 1),
        .ARM (ARM)
    ) u_shape (
        .dx   (dx),
        .dy   (dy),
        .mode (cur_mode_e'(mode)),
        .hit  (hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= X_HOME;
            y_q         <= Y_HOME;
            pend_q      <= 4'b0000;
            cnt_q       <= 8'd0;
            vis_q       <= 1'b1;
            is_cursor_q <= 1'b0;
        end else begin
            if (frame_tick) begin
                x_q <= x_d;
                y_q <= y_d;
            end
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            vis_q       <= vis_d;
            is_cursor_q <= pixelActive && vis_q && hit;
        end
    end

    assign cursorX  = x_q;
    assign cursorY  = y_q;
    assign isCursor = is_cursor_q;

endmodule

// File: tb/tb_cursor_engine.sv
// Directed bench for cursor_engine: a STEP=1/BLINK_FRAMES=3 instance and a
// STEP=4 instance share all stimulus and are checked against hand values.
module tb_cursor_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic       move_up, move_down, move_left, move_right;
    logic [1:0] mode;
    logic       blink_en;
    logic [9:0] xPos;
    logic [8:0] yPos;
    logic       pixelActive;

    logic [9:0] cx1, cx4;
    logic [8:0] cy1, cy4;
    logic       ic1, ic4;

    int total = 0;
    int bad   = 0;
    int ex1, ey1;

    always #5 clk = ~clk;

    cursor_engine #(.STEP(1), .BLINK_FRAMES(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
        .mode(mode), .blink_en(blink_en), .xPos(xPos), .yPos(yPos), .pixelActive(pixelActive),
        .cursorX(cx1), .cursorY(cy1), .isCursor(ic1)
    );

    cursor_engine #(.STEP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
        .mode(mode), .blink_en(blink_en), .xPos(xPos), .yPos(yPos), .pixelActive(pixelActive),
        .cursorX(cx4), .cursorY(cy4), .isCursor(ic4)
    );

    // shape vectors with both cursors at (320,240): mode, x, y, expected hit
    int sv_m [16] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3, 0};
    int sv_x [16] = '{320, 322, 323, 320, 318, 321, 322, 321, 321, 320, 323, 5, 320, 5, 320, 320};
    int sv_y [16] = '{238, 240, 240, 237, 240, 241, 238, 242, 239, 240, 240, 240, 7, 7, 240, 240};
    int sv_e [16] = '{1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ftick(input logic u, input logic d, input logic l, input logic r);
        move_up = u; move_down = d; move_left = l; move_right = r;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        move_up = 1'b0; move_down = 1'b0; move_left = 1'b0; move_right = 1'b0;
    endtask

    task automatic pulse(input logic u, input logic d, input logic l, input logic r);
        move_up = u; move_down = d; move_left = l; move_right = r;
        tick();
        move_up = 1'b0; move_down = 1'b0; move_left = 1'b0; move_right = 1'b0;
    endtask

    task automatic pix(input int x, input int y);
        xPos = 10'(x);
        yPos = 9'(y);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if (cx1 !== 10'd320 || cy1 !== 9'd240 || cx4 !== 10'd320 || cy4 !== 9'd240) begin
            bad++;
            $display("FAIL reset_pos got (%0d,%0d)/(%0d,%0d) want (320,240)", cx1, cy1, cx4, cy4);
        end
        total++;
        if (ic1 !== 1'b0 || ic4 !== 1'b0) begin
            bad++;
            $display("FAIL reset_iscursor got %b/%b want 0", ic1, ic4);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (cx1 !== 10'd320 || cy1 !== 9'd240) begin
            bad++;
            $display("FAIL reset_release_pos got (%0d,%0d) want (320,240)", cx1, cy1);
        end
        ex1 = 320;
        ey1 = 240;
    endtask

    task automatic test_shapes();
        blink_en    = 1'b0;
        pixelActive = 1'b1;
        for (int i = 0; i < 16; i++) begin
            mode        = 2'(sv_m[i]);
            pixelActive = (i != 15);
            pix(sv_x[i], sv_y[i]);
            total++;
            if (ic1 !== 1'(sv_e[i]) || ic4 !== 1'(sv_e[i])) begin
                bad++;
                $display("FAIL shape_%0d mode=%0d pix=(%0d,%0d) got %b/%b want %0d",
                         i, sv_m[i], sv_x[i], sv_y[i], ic1, ic4, sv_e[i]);
            end
        end
        pixelActive = 1'b1;
        mode        = 2'd0;
    endtask

    task automatic test_move_deferred();
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) tick();
        total++;
        if (cx1 !== 10'd320 || cx4 !== 10'd320) begin
            bad++;
            $display("FAIL defer_before got %0d/%0d want 320", cx1, cx4);
        end
        ftick(1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (cx1 !== 10'd321 || cx4 !== 10'd324 || cy1 !== 9'd240) begin
            bad++;
            $display("FAIL defer_after got x=%0d/%0d y=%0d want 321/324 240", cx1, cx4, cy1);
        end
        ex1 = 321;
    endtask

    task automatic test_coincident();
        ftick(1'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if (cy1 !== 9'd241 || cy4 !== 9'd244) begin
            bad++;
            $display("FAIL coincident_down got %0d/%0d want 241/244", cy1, cy4);
        end
        ey1 = 241;
    endtask

    task automatic test_conflict();
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        ftick(1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (cx1 !== 10'd321 || cy1 !== 9'd241 || cx4 !== 10'd324 || cy4 !== 9'd244) begin
            bad++;
            $display("FAIL conflict_cancel got (%0d,%0d)/(%0d,%0d) want (321,241)/(324,244)",
                     cx1, cy1, cx4, cy4);
        end
        ftick(1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (cx1 !== 10'd321 || cy1 !== 9'd241) begin
            bad++;
            $display("FAIL conflict_idle got (%0d,%0d) want (321,241)", cx1, cy1);
        end
        // a stale left flag would cancel this right move
        ftick(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (cx1 !== 10'd322 || cx4 !== 10'd328) begin
            bad++;
            $display("FAIL conflict_cleared got %0d/%0d want 322/328", cx1, cx4);
        end
        ex1 = 322;
    endtask

    task automatic test_blink();
        mode     = 2'd0;
        blink_en = 1'b1;
        pix(ex1, ey1);
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) begin
                ftick(1'b0, 1'b0, 1'b0, 1'b0);
                tick();
            end
            total++;
            if (ic1 !== 1'(((k % 6) < 3) ? 1 : 0)) begin
                bad++;
                $display("FAIL blink_frame_%0d got %b want %0d", k, ic1, ((k % 6) < 3) ? 1 : 0);
            end
        end
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        ftick(1'b0, 1'b0, 1'b0, 1'b0);
        ex1 = ex1 - 1;
        pix(ex1, ey1);
        total++;
        if (ic1 !== 1'b1 || cx1 !== 10'(ex1)) begin
            bad++;
            $display("FAIL blink_move_reveal got ic=%b x=%0d want 1 x=%0d", ic1, cx1, ex1);
        end
        ftick(1'b0, 1'b0, 1'b0, 1'b0);
        ftick(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        total++;
        if (ic1 !== 1'b1) begin
            bad++;
            $display("FAIL blink_after_move_on got %b want 1", ic1);
        end
        ftick(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        total++;
        if (ic1 !== 1'b0) begin
            bad++;
            $display("FAIL blink_after_move_off got %b want 0", ic1);
        end
        blink_en = 1'b0;
        tick();
        tick();
        total++;
        if (ic1 !== 1'b1) begin
            bad++;
            $display("FAIL blink_disable got %b want 1", ic1);
        end
    endtask

    task automatic test_reset_midframe();
        pix(ex1, ey1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #2;
        total++;
        if (cx1 !== 10'd320 || cy1 !== 9'd240 || ic1 !== 1'b0 || cx4 !== 10'd320 || cy4 !== 9'd240) begin
            bad++;
            $display("FAIL midreset_async got (%0d,%0d) ic=%b dut4 (%0d,%0d) want (320,240) ic=0",
                     cx1, cy1, ic1, cx4, cy4);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        ftick(1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (cx1 !== 10'd320 || cy1 !== 9'd240 || cx4 !== 10'd320 || cy4 !== 9'd240) begin
            bad++;
            $display("FAIL midreset_discard got (%0d,%0d)/(%0d,%0d) want (320,240)", cx1, cy1, cx4, cy4);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 80; i++) ftick(1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if (cx4 !== 10'd639 || cy4 !== 9'd0) begin
            bad++;
            $display("FAIL sat_step4 got (%0d,%0d) want (639,0)", cx4, cy4);
        end
        total++;
        if (cx1 !== 10'd400 || cy1 !== 9'd160) begin
            bad++;
            $display("FAIL sat_step1 got (%0d,%0d) want (400,160)", cx1, cy1);
        end
        ftick(1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if (cx4 !== 10'd639 || cy4 !== 9'd0) begin
            bad++;
            $display("FAIL sat_hold got (%0d,%0d) want (639,0)", cx4, cy4);
        end
        mode = 2'd1;
        pix(0, 2);
        total++;
        if (ic4 !== 1'b0) begin
            bad++;
            $display("FAIL box_nowrap got %b want 0", ic4);
        end
        pix(639, 2);
        total++;
        if (ic4 !== 1'b1) begin
            bad++;
            $display("FAIL box_edge_bottom got %b want 1", ic4);
        end
        pix(637, 0);
        total++;
        if (ic4 !== 1'b1) begin
            bad++;
            $display("FAIL box_edge_left got %b want 1", ic4);
        end
        ftick(1'b0, 1'b0, 1'b1, 1'b0);
        total++;
        if (cx4 !== 10'd635) begin
            bad++;
            $display("FAIL step4_left got %0d want 635", cx4);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_tick  = 1'b0;
        move_up     = 1'b0;
        move_down   = 1'b0;
        move_left   = 1'b0;
        move_right  = 1'b0;
        mode        = 2'd0;
        blink_en    = 1'b0;
        xPos        = 10'd0;
        yPos        = 9'd0;
        pixelActive = 1'b1;

        test_reset();
        test_shapes();
        test_move_deferred();
        test_coincident();
        test_conflict();
        test_blink();
        test_reset_midframe();
        test_saturate();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
